// File: rtl/ddr_burst_pkg.sv
// ddr_burst_pkg: shared constants and responder state encoding for the DDR burst interface
package ddr_burst_pkg;
  localparam int DDR_DATA_W  = 128;
  localparam int DDR_ADDR_W  = 28;
  localparam int BURST_LEN_W = 10;
  typedef enum logic [2:0] {IDLE, WR_BEAT, WR_FIN, RD_ISSUE, RD_DRAIN, RD_FIN} state_t;
endpackage

// File: rtl/ddr_resp_ram.sv
// ddr_resp_ram: simple dual-port word RAM, one write port, one registered read port, no reset
module ddr_resp_ram #(
  parameter int DW = 128,
  parameter int AW = 12
) (
  input  logic          mem_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge mem_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ddr_burst_responder.sv
// ddr_burst_responder: serves DDR rd/wr bursts from on-chip RAM (MIG stand-in).
// Define DDR_RESP_STALL_EN to insert a bubble every STALL_PERIOD-th beat slot.
module ddr_burst_responder
  import ddr_burst_pkg::*;
#(
  parameter int DDR_DATA_WIDTH = DDR_DATA_W,
  parameter int DDR_ADDR_WIDTH = DDR_ADDR_W,
  parameter int MEM_AW         = 12,
  parameter int STALL_PERIOD   = 4
) (
  input  logic                      mem_clk,
  input  logic                      rst,
  input  logic                      rd_burst_req,
  input  logic [BURST_LEN_W-1:0]    rd_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  input  logic                      wr_burst_req,
  input  logic [BURST_LEN_W-1:0]    wr_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  input  logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
  output logic                      wr_burst_data_req,
  output logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  output logic                      rd_burst_data_valid,
  output logic                      rd_burst_finish,
  output logic                      wr_burst_finish,
  output logic                      busy
);
  state_t state, state_n;
  logic [MEM_AW-1:0] addr;
  logic [BURST_LEN_W-1:0] len, cnt;
  logic [DDR_DATA_WIDTH-1:0] ram_q;
  logic stall, issue, issue_d, last;
  logic unused_addr;
  assign unused_addr = ^{wr_burst_addr[DDR_ADDR_WIDTH-1:MEM_AW], rd_burst_addr[DDR_ADDR_WIDTH-1:MEM_AW]};
`ifdef DDR_RESP_STALL_EN
  localparam int SW = $clog2(STALL_PERIOD);
  logic [SW-1:0] slot;
  // slot phase restarts with every burst so each burst sees the same bubble pattern
  always_ff @(posedge mem_clk)
    slot <= (rst || !(state inside {WR_BEAT, RD_ISSUE}) || slot == SW'(STALL_PERIOD - 1)) ? '0 : slot + 1'b1;
  assign stall = slot == SW'(STALL_PERIOD - 1);
`else
  logic unused_stall;
  assign unused_stall = STALL_PERIOD[0];
  assign stall = 1'b0;
`endif
  assign wr_burst_data_req = state == WR_BEAT && !stall;
  assign issue             = state == RD_ISSUE && !stall;
  assign last              = cnt == len - 1'b1;
  assign wr_burst_finish   = state == WR_FIN;
  assign rd_burst_finish   = state == RD_FIN;
  assign busy              = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = wr_burst_req ? (wr_burst_len == '0 ? WR_FIN : WR_BEAT)
                        : rd_burst_req ? (rd_burst_len == '0 ? RD_FIN : RD_ISSUE) : IDLE;
      WR_BEAT:  state_n = wr_burst_data_req && last ? WR_FIN : WR_BEAT;
      WR_FIN:   state_n = IDLE;
      RD_ISSUE: state_n = issue && last ? RD_DRAIN : RD_ISSUE;
      // leave only once the last beat sits in the output register, so finish never overlaps data
      RD_DRAIN: state_n = issue_d ? RD_DRAIN : RD_FIN;
      RD_FIN:   state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      issue_d             <= 1'b0;
      rd_burst_data_valid <= 1'b0;
      rd_burst_data       <= '0;
    end else begin
      state               <= state_n;
      issue_d             <= issue;
      rd_burst_data_valid <= issue_d;
      if (issue_d) rd_burst_data <= ram_q;
      if (state == IDLE) begin
        addr <= wr_burst_req ? wr_burst_addr[MEM_AW-1:0] : rd_burst_addr[MEM_AW-1:0];
        len  <= wr_burst_req ? wr_burst_len : rd_burst_len;
        cnt  <= '0;
      end else if (wr_burst_data_req || issue) begin
        addr <= addr + 1'b1;
        cnt  <= cnt + 1'b1;
      end
    end
  end
  ddr_resp_ram #(.DW(DDR_DATA_WIDTH), .AW(MEM_AW)) u_ram (
    .mem_clk(mem_clk),
    .we(wr_burst_data_req),
    .waddr(addr),
    .wdata(wr_burst_data),
    .raddr(addr),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_ddr_burst_responder.sv
// tb_ddr_burst_responder: directed self-checking bench for ddr_burst_responder
module tb_ddr_burst_responder;
  logic         mem_clk = 1'b0;
  logic         rst;
  logic         rd_burst_req, wr_burst_req;
  logic [9:0]   rd_burst_len, wr_burst_len;
  logic [27:0]  rd_burst_addr, wr_burst_addr;
  logic [127:0] wr_burst_data, rd_burst_data;
  logic         wr_burst_data_req, rd_burst_data_valid, rd_burst_finish, wr_burst_finish, busy;
  int total = 0;
  int bad = 0;
  logic [127:0] rq[$];
  logic [31:0] pat;
  int np;

  ddr_burst_responder dut (
    .mem_clk(mem_clk), .rst(rst),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
    .rd_burst_data(rd_burst_data), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish), .busy(busy)
  );

  always #5 mem_clk = ~mem_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic wr_burst(input logic [27:0] a, input logic [9:0] n, input logic [127:0] base,
                          output logic [31:0] p, output int k);
    int beats = 0;
    p = '0;
    k = 0;
    wr_burst_addr = a;
    wr_burst_len  = n;
    wr_burst_data = base;
    wr_burst_req  = 1'b1;
    tick();
    while (!wr_burst_finish && k < 64) begin
      p = {p[30:0], wr_burst_data_req};
      k++;
      wr_burst_data = base + 128'(beats);
      if (wr_burst_data_req) beats++;
      tick();
    end
    check("wr_finish_seen", wr_burst_finish, 1'b1);
    check("wr_finish_no_data_req", wr_burst_data_req, 1'b0);
    wr_burst_req = 1'b0;
    tick();
    check("wr_finish_one_cycle", wr_burst_finish, 1'b0);
  endtask

  task automatic rd_burst(input logic [27:0] a, input logic [9:0] n, output logic [31:0] p, output int k);
    rq.delete();
    p = '0;
    k = 0;
    rd_burst_addr = a;
    rd_burst_len  = n;
    rd_burst_req  = 1'b1;
    tick();
    while (!rd_burst_finish && k < 64) begin
      p = {p[30:0], rd_burst_data_valid};
      k++;
      if (rd_burst_data_valid) rq.push_back(rd_burst_data);
      tick();
    end
    check("rd_finish_seen", rd_burst_finish, 1'b1);
    check("rd_finish_no_valid", rd_burst_data_valid, 1'b0);
    rd_burst_req = 1'b0;
    tick();
    check("rd_finish_one_cycle", rd_burst_finish, 1'b0);
  endtask

  task automatic chk_rd(input string tag, input int n, input logic [127:0] base);
    check({tag, "_count"}, 128'(rq.size()), 128'(n));
    for (int i = 0; i < n; i++) check(tag, (i < rq.size()) ? rq[i] : 'x, base + 128'(i));
  endtask

  initial begin
    rst = 1'b1;
    rd_burst_req = 1'b0;
    wr_burst_req = 1'b0;
    rd_burst_len = '0;
    wr_burst_len = '0;
    rd_burst_addr = '0;
    wr_burst_addr = '0;
    wr_burst_data = '0;
    repeat (3) tick();
    check("rst_data_req", wr_burst_data_req, 1'b0);
    check("rst_valid", rd_burst_data_valid, 1'b0);
    check("rst_rd_data", rd_burst_data, '0);
    check("rst_rd_finish", rd_burst_finish, 1'b0);
    check("rst_wr_finish", wr_burst_finish, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // basic write then read-back; address 0x8000 maps to RAM word 0x000
    wr_burst(28'h8000, 10'd4, 128'h11, pat, np);
`ifdef DDR_RESP_STALL_EN
    check("t1_wr_pattern", pat, 32'b11101);
    check("t1_wr_cycles", 128'(np), 128'd5);
`else
    check("t1_wr_pattern", pat, 32'b1111);
    check("t1_wr_cycles", 128'(np), 128'd4);
`endif
    check("t1_busy_drop", busy, 1'b0);
    rd_burst(28'h8000, 10'd4, pat, np);
`ifdef DDR_RESP_STALL_EN
    check("t1_rd_pattern", pat, 32'b0011101);
    check("t1_rd_cycles", 128'(np), 128'd7);
`else
    check("t1_rd_pattern", pat, 32'b001111);
    check("t1_rd_cycles", 128'(np), 128'd6);
`endif
    chk_rd("t1_rd_data", 4, 128'h11);

    // wrap at the top of the RAM
    wr_burst(28'hFFE, 10'd3, 128'h21, pat, np);
    check("t2_wr_pattern", pat, 32'b111);
    rd_burst(28'hFFE, 10'd3, pat, np);
    chk_rd("t2_rd_wrap", 3, 128'h21);
    rd_burst(28'h000, 10'd1, pat, np);
    chk_rd("t2_rd_word0", 1, 128'h23);
    rd_burst(28'h1001, 10'd1, pat, np);
    chk_rd("t2_rd_upper_ignored", 1, 128'h12);

    // zero-length bursts finish without any data handshake
    wr_burst(28'h300, 10'd0, 128'h0, pat, np);
    check("t3_wr_len0_cycles", 128'(np), 128'd0);
    rd_burst(28'h300, 10'd0, pat, np);
    check("t3_rd_len0_cycles", 128'(np), 128'd0);
    check("t3_rd_len0_beats", 128'(rq.size()), 128'd0);

    // simultaneous requests: write first, read sees the freshly written words
    rd_burst_addr = 28'h100;
    rd_burst_len  = 10'd2;
    rd_burst_req  = 1'b1;
    wr_burst(28'h100, 10'd2, 128'h41, pat, np);
    check("t4_wr_first", pat, 32'b11);
    check("t4_idle_between", busy, 1'b0);
    rd_burst(28'h100, 10'd2, pat, np);
    chk_rd("t4_rd_after_wr", 2, 128'h41);

    // reset in the middle of a long read
    rd_burst_addr = 28'h0;
    rd_burst_len  = 10'd16;
    rd_burst_req  = 1'b1;
    repeat (4) tick();
    check("t5_beat2_valid", rd_burst_data_valid, 1'b1);
    rst = 1'b1;
    tick();
    check("t5_rst_valid", rd_burst_data_valid, 1'b0);
    check("t5_rst_data", rd_burst_data, '0);
    check("t5_rst_finish", rd_burst_finish, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    rst = 1'b0;
    rd_burst_req = 1'b0;
    tick();
    check("t5_no_finish", rd_burst_finish, 1'b0);
    check("t5_idle", busy, 1'b0);
    rd_burst(28'h002, 10'd1, pat, np);
    chk_rd("t5_ram_kept", 1, 128'h13);

    // longer write exposing the bubble pattern when stalls are enabled
    wr_burst(28'h200, 10'd8, 128'h61, pat, np);
`ifdef DDR_RESP_STALL_EN
    check("t6_wr_pattern", pat, 32'b1110111011);
    check("t6_wr_cycles", 128'(np), 128'd10);
`else
    check("t6_wr_pattern", pat, 32'b11111111);
    check("t6_wr_cycles", 128'(np), 128'd8);
`endif
    rd_burst(28'h200, 10'd8, pat, np);
    chk_rd("t6_rd_data", 8, 128'h61);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
